// File: rtl/enc7to3_arb.sv
// 7-requester arbiter/encoder with valid/ack grant handshake.
// Define ENC_ROUND_ROBIN_EN for round-robin selection; default is fixed priority (lowest index).
module enc7to3_arb #(
  parameter int unsigned NREQ = 7,
  parameter int unsigned IW   = 3
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            E,
  input  logic [NREQ-1:0] Req,
  input  logic            Ack,
  output logic [IW-1:0]   W,
  output logic            Valid,
  output logic            Multi
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [IW-1:0] TOP_IDX = IW'(NREQ - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] w_q, w_d;
  logic          multi_q, multi_d;
  logic [IW-1:0] sel_c;
  logic          grant_c;

`ifdef ENC_ROUND_ROBIN_EN
  logic [IW-1:0] last_q, last_d;

  // Walk Last+1, Last+2, ... with wrap 6->0; first requester found wins.
  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    sel_c = '0;
    found = 1'b0;
    idx   = last_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (idx == TOP_IDX) ? '0 : idx + IW'(1);
      if (!found && Req[idx]) begin
        found = 1'b1;
        sel_c = idx;
      end
    end
  end
`else
  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    logic [IW-1:0] idx;
    sel_c = '0;
    idx   = TOP_IDX;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (Req[idx]) sel_c = idx;
      idx = idx - IW'(1);
    end
  end
`endif

  // A grant is made from IDLE, or back-to-back when the current one is acked.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    multi_d = multi_q;
`ifdef ENC_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    grant_c = E && (|Req) && ((state_q == ST_IDLE) || Ack);
    if (grant_c) begin
      state_d = ST_GRANT;
      w_d     = sel_c;
      multi_d = ($countones(Req) > 1);
`ifdef ENC_ROUND_ROBIN_EN
      last_d  = sel_c;
`endif
    end else if ((state_q == ST_GRANT) && Ack) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      multi_q <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      last_q  <= TOP_IDX;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      multi_q <= multi_d;
`ifdef ENC_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign W     = w_q;
  assign Valid = (state_q == ST_GRANT);
  assign Multi = multi_q;

endmodule

// File: doc/enc7to3_arb.md
# enc7to3_arb

Registered 7-requester arbiter/encoder for the processor datapath. It collapses one-hot-or-wider request lines from the seven register slots into a single 3-bit register index, so the index can drive the 3-to-8 register-enable decoding path. A grant is held under a valid/ack handshake until the control unit consumes it. Arbitration is round-robin or fixed-priority, selected at compile time.

## Interface
Parameters:
- NREQ, 7, number of request lines; fixed at 7, and other values are unsupported.
- IW, 3, encoded index width.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- E  in  1  enable; when low, no new grant is issued.
- Req  in  7  request lines; Req[i] high means slot i requests.
- Ack  in  1  consumer accepts the current grant.
- W  out  3  granted index, 0..6; value 7 is never produced.
- Valid  out  1  W holds a grant not yet accepted.
- Multi  out  1  more than one Req bit was high when the current W was granted.

## Operation
- State machine: IDLE (Valid=0) and GRANT (Valid=1).
- IDLE to GRANT: on an edge where E=1 and Req≠0.
  - Load W with the selected index.
  - Set Multi = (popcount(Req) > 1).
  - Set Last = W.
- GRANT, Ack=0: W, Multi and Valid hold, regardless of E or Req changes.
- GRANT, Ack=1:
  - If E=1 and Req≠0, grant again on that same edge. This is back-to-back: Valid stays 1 and W, Multi and Last update.
  - Otherwise go to IDLE. Valid goes to 0; W and Multi hold their last values.
- Ack in IDLE is ignored.
- Selection with round-robin: search indices Last+1, Last+2, … modulo 7, wrapping 6→0. Take the first index with Req set.
- Selection with fixed priority: lowest set index wins, and Last is unused for selection.
- Last is an internal 3-bit pointer with range 0..6.
- A requester that keeps Req high after its Ack is eligible again.
  - Under round-robin it is considered last.
  - Under fixed priority it wins again if it is still the lowest.
- Req bits are sampled only on edges where a grant is being made.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: Req/E sampled at edge k; W/Valid/Multi valid after edge k, one cycle.
- Handshake completes on an edge with Valid=1 and Ack=1. Throughput is up to one grant per cycle.
- Reset values: W=0, Valid=0, Multi=0, Last=6, so the first round-robin search starts at 0.
- Reset is asynchronous. Asserting Resetn=0 mid-grant clears outputs immediately, with no pending grant retained.
- E falling during GRANT does not cancel the grant. It only blocks the next one.
- Simultaneous Ack and new Req: the new grant takes effect on that edge, with no idle bubble.

## Configuration
- ENC_ROUND_ROBIN_EN:
  - Defined: round-robin selection from Last+1 with wrap-around; Last is updated on every grant.
  - Not defined: fixed priority, lowest index wins. The Last register may be removed, and all other behaviour is identical.

## Test plan
- Reset with Req=7'b0000000, then Req=7'b0100000, E=1 → one cycle later W=5, Valid=1, Multi=0; W holds for 3 cycles with Ack=0; Ack=1 with Req=0 → Valid=0 next cycle, W stays 5.
- Round-robin defined, Req=7'b1111111 held, E=1, Ack=1 every cycle → W sequence 0,1,2,3,4,5,6,0 with Valid continuously 1 and Multi=1.
- Fixed priority (macro undefined), same stimulus → W=0 every cycle.
- Round-robin, Req=7'b1000001, after grant W=6 → next grant W=0, checking the wrap; then Req=7'b0000001 only → W=0 again.
- Grant pending (W=3, Valid=1), drop E and change Req to 7'b0000100 → W stays 3 until Ack; after Ack with E=0 → Valid=0 and no new grant.
- Assert Resetn=0 mid-cycle while Valid=1, W=4 → W=0, Valid=0, Multi=0 immediately, before the next edge; after release with Req=7'b1111111 → first grant W=0.
